// File: rtl/fhalf_pkg.sv
// Shared binary32 field definitions for the FPU datapath blocks.
// Holds the field widths, the exponent bias and the unpacked operand struct.
package fhalf_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/fhalf_core.sv
// Combinational binary32 halving: y = x / 2 with round-to-nearest-even.
// Inputs with a zero exponent flush to signed zero. Inf and NaN pass through unchanged.
module fhalf_core
  import fhalf_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);

  fp32_t       a;
  fp32_t       r;
  logic [23:0] t;
  logic [22:0] q;
  logic        g;
  logic        rup;
  logic [23:0] q_rnd;

  assign a = fp32_t'(x);

  // Alignment for the e == 1 case. The hidden bit moves into the mantissa,
  // and the bit shifted out becomes the guard bit.
  assign t     = {1'b1, a.man};
  assign q     = t[23:1];
  assign g     = t[0];
  assign rup   = g & q[0];
  assign q_rnd = {1'b0, q} + {23'd0, rup};

  always_comb begin
    r      = a;
    r.sign = a.sign;
    if (a.exp == EXP_MAX) begin
      r = a;
    end else if (a.exp == '0) begin
      r.exp = '0;
      r.man = '0;
    end else if (a.exp == 8'd1) begin
      // A carry out of the rounded mantissa lands in the exponent LSB.
      r.exp = {7'd0, q_rnd[23]};
      r.man = q_rnd[22:0];
    end else begin
      r.exp = a.exp - 8'd1;
      r.man = a.man;
    end
  end

  assign y = r;

endmodule

// File: rtl/fhalf.sv
// Binary32 divide-by-two unit. It wraps fhalf_core with an optional output register.
// When REG_OUT=1, the output has 1 cycle of latency and rstn clears it asynchronously to zero.
module fhalf
  import fhalf_pkg::*;
#(
  parameter bit REG_OUT = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic [31:0] y_comb;

  fhalf_core u_core (
    .x (x),
    .y (y_comb)
  );

  generate
    if (REG_OUT) begin : g_reg
      logic [31:0] y_q;

      // rstn is active-high despite its name.
      always_ff @(posedge clk or posedge rstn) begin
        if (rstn) y_q <= '0;
        else      y_q <= y_comb;
      end

      assign y = y_q;
    end else begin : g_comb
      logic unused_ok;
      assign unused_ok = clk ^ rstn;
      assign y = y_comb;
    end
  endgenerate

endmodule

// File: tb/tb_fhalf.sv
// Directed-vector bench for fhalf. It drives the same x into a combinational instance and a registered instance.
// It also runs hand-written sequences for output latency and for asynchronous reset of the registered output.
module tb_fhalf;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  logic        clk;
  logic        rstn;
  logic [31:0] x;
  logic [31:0] y0;
  logic [31:0] y1;

  int n_vec;
  int n_err;

  fhalf #(.REG_OUT(1'b0)) u_comb (
    .clk  (clk),
    .rstn (rstn),
    .x    (x),
    .y    (y0)
  );

  fhalf #(.REG_OUT(1'b1)) u_reg (
    .clk  (clk),
    .rstn (rstn),
    .x    (x),
    .y    (y1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  vec_t tbl[$];

  initial begin
    n_vec = 0;
    n_err = 0;
    tbl = '{
      '{32'h3F800000, 32'h3F000000},
      '{32'hC0C00000, 32'hC0400000},
      '{32'h00800000, 32'h00400000},
      '{32'h00800001, 32'h00400000},
      '{32'h00800003, 32'h00400002},
      '{32'h00800002, 32'h00400001},
      '{32'h00FFFFFF, 32'h00800000},
      '{32'h00FFFFFE, 32'h007FFFFF},
      '{32'h80800001, 32'h80400000},
      '{32'h01000000, 32'h00800000},
      '{32'h7F7FFFFF, 32'h7EFFFFFF},
      '{32'hFF7FFFFF, 32'hFEFFFFFF},
      '{32'h7F800000, 32'h7F800000},
      '{32'hFF800000, 32'hFF800000},
      '{32'h7FC00001, 32'h7FC00001},
      '{32'h80000000, 32'h80000000},
      '{32'h00000000, 32'h00000000},
      '{32'h00000001, 32'h00000000},
      '{32'h807FFFFF, 32'h80000000}
    };

    rstn = 1'b1;
    x    = 32'h3F800000;
    #1;
    check("reset_y_reg", y1, 32'h0);
    check("comb_during_reset", y0, 32'h3F000000);
    @(posedge clk);
    #1;
    check("reset_hold_edge", y1, 32'h0);

    @(negedge clk);
    rstn = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      x = tbl[i].x;
      #1;
      check($sformatf("comb[%0d]", i), y0, tbl[i].y);
      @(posedge clk);
      #1;
      check($sformatf("reg[%0d]", i), y1, tbl[i].y);
    end

    // The registered output must not follow x until the next rising edge.
    @(negedge clk);
    x = 32'h40000000;
    #1;
    check("latency_hold", y1, 32'h80000000);
    check("latency_comb", y0, 32'h3F800000);
    @(posedge clk);
    #1;
    check("latency_update", y1, 32'h3F800000);

    // Asserting reset mid-cycle discards the in-flight result immediately.
    @(negedge clk);
    x = 32'h41000000;
    #2;
    rstn = 1'b1;
    #1;
    check("async_reset_clear", y1, 32'h0);
    @(posedge clk);
    #1;
    check("reset_blocks_capture", y1, 32'h0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("release_no_edge", y1, 32'h0);
    @(posedge clk);
    #1;
    check("first_after_release", y1, 32'h40800000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
